// File: rtl/receive_beamformer.sv
// Receive delay-and-sum beamformer: per-channel circular delay lines steered by a signed sine.
// Define RX_AVERAGE_EN to divide the beam sum by NUM_RECEIVERS (arithmetic shift).
module receive_beamformer #(
  parameter int NUM_RECEIVERS = 4,
  parameter int SAMPLE_WIDTH  = 12,
  parameter int SIN_WIDTH     = 16,
  parameter int DELAY_STEP    = 15,
  parameter int DEPTH         = 64,
  localparam int SUM_WIDTH    = SAMPLE_WIDTH + $clog2(NUM_RECEIVERS)
) (
  input  logic                                    clk_in,
  input  logic                                    rst_in,
  input  logic                                    sample_valid_in,
  input  logic [NUM_RECEIVERS*SAMPLE_WIDTH-1:0]   samples_in,
  input  logic                                    steer_valid_in,
  input  logic [SIN_WIDTH-1:0]                    steer_sin_in,
  output logic signed [SUM_WIDTH-1:0]             sum_out,
  output logic                                    sum_valid_out,
  output logic                                    filled_out,
  output logic                                    state_out
);

  // Handshake: sample_valid_in is a one-cycle strobe that is always accepted
  // (no ready); sum_valid_out pulses for one cycle, one edge after acceptance.

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int AVG_SH = $clog2(NUM_RECEIVERS);
  localparam int PROD_W = SIN_WIDTH + 32;

  typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

  state_t                      state_q, state_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            fill_cnt_q, fill_cnt_d;
  logic [PTR_W-1:0]            delay_q [NUM_RECEIVERS];
  logic [PTR_W-1:0]            delay_d [NUM_RECEIVERS];
  logic [PTR_W-1:0]            delay_calc [NUM_RECEIVERS];
  logic signed [SUM_WIDTH-1:0] sum_q, sum_d;
  logic                        sum_valid_q, sum_valid_d;
  logic [SAMPLE_WIDTH-1:0]     mem_q [NUM_RECEIVERS][DEPTH];

  logic [SIN_WIDTH-2:0]        s_mag;
  logic [PROD_W-1:0]           prod, scaled;
  int                          m_idx;
  logic [PTR_W-1:0]            rd_idx;
  logic signed [SAMPLE_WIDTH-1:0] tap;
  logic signed [SUM_WIDTH-1:0] acc, beam;

  // Magnitude of the sine; the most negative code saturates to full scale.
  always_comb begin
    if (!steer_sin_in[SIN_WIDTH-1])
      s_mag = steer_sin_in[SIN_WIDTH-2:0];
    else if (steer_sin_in[SIN_WIDTH-2:0] == '0)
      s_mag = '1;
    else
      s_mag = (~steer_sin_in[SIN_WIDTH-2:0]) + 1'b1;
  end

  always_comb begin
    prod   = '0;
    scaled = '0;
    m_idx  = 0;
    for (int i = 0; i < NUM_RECEIVERS; i++) begin
      m_idx  = steer_sin_in[SIN_WIDTH-1] ? (NUM_RECEIVERS - 1 - i) : i;
      prod   = PROD_W'(DELAY_STEP) * PROD_W'(m_idx) * PROD_W'(s_mag);
      scaled = prod >> (SIN_WIDTH - 1);
      delay_calc[i] = (scaled > PROD_W'(DEPTH - 1)) ? PTR_W'(DEPTH - 1) : PTR_W'(scaled);
      delay_d[i]    = steer_valid_in ? delay_calc[i] : delay_q[i];
    end
  end

  // Zero delay bypasses the buffer: the slot under the write pointer is stale.
  always_comb begin
    acc    = '0;
    tap    = '0;
    rd_idx = '0;
    for (int i = 0; i < NUM_RECEIVERS; i++) begin
      rd_idx = wr_ptr_q - delay_q[i];
      tap    = (delay_q[i] == '0) ? samples_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]
                                  : mem_q[i][rd_idx];
      acc    = acc + SUM_WIDTH'(tap);
    end
`ifdef RX_AVERAGE_EN
    beam = acc >>> AVG_SH;
`else
    beam = acc;
`endif
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;
    if (sample_valid_in) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      case (state_q)
        FILL: begin
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q == PTR_W'(DEPTH - 1)) begin
            state_d     = RUN;
            sum_valid_d = 1'b1;
            sum_d       = beam;
          end
        end
        RUN: begin
          sum_valid_d = 1'b1;
          sum_d       = beam;
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      for (int i = 0; i < NUM_RECEIVERS; i++) delay_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      for (int i = 0; i < NUM_RECEIVERS; i++) delay_q[i] <= delay_d[i];
    end
  end

  // Buffer contents are deliberately never cleared.
  always_ff @(posedge clk_in) begin
    if (rst_in && sample_valid_in) begin
      for (int i = 0; i < NUM_RECEIVERS; i++)
        mem_q[i][wr_ptr_q] <= samples_in[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end
  end

  assign sum_out       = sum_q;
  assign sum_valid_out = sum_valid_q;
  assign filled_out    = (state_q == RUN);
  assign state_out     = state_q;

endmodule

// File: tb/tb_receive_beamformer.sv
// Bench for receive_beamformer: steering table vectors, hand sequences and random stimulus
// compared against a sample-history reference model.
module tb_receive_beamformer;

  localparam int NR    = 4;
  localparam int SW    = 12;
  localparam int SINW  = 16;
  localparam int STEP  = 15;
  localparam int DEPTH = 64;
  localparam int SUMW  = SW + $clog2(NR);
  localparam int MAXS  = 4096;
`ifdef RX_AVERAGE_EN
  localparam int PEAK  = 1000;
  localparam int CONST = 100;
`else
  localparam int PEAK  = 4000;
  localparam int CONST = 400;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   sv;
  logic [NR*SW-1:0]       smp;
  logic                   stv;
  logic signed [SINW-1:0] sin;
  logic signed [SUMW-1:0] sum_out;
  logic                   sum_valid;
  logic                   filled;
  logic                   state_dbg;

  receive_beamformer #(
    .NUM_RECEIVERS(NR), .SAMPLE_WIDTH(SW), .SIN_WIDTH(SINW),
    .DELAY_STEP(STEP), .DEPTH(DEPTH)
  ) dut (
    .clk_in(clk), .rst_in(rst_n), .sample_valid_in(sv), .samples_in(smp),
    .steer_valid_in(stv), .steer_sin_in(sin), .sum_out(sum_out),
    .sum_valid_out(sum_valid), .filled_out(filled), .state_out(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [SUMW-1:0] exp_q[$];
  int hist [NR][MAXS];
  int k;
  int dly [NR];
  int last_sum;

  typedef struct {
    logic signed [SINW-1:0] sin;
    int d [NR];
    int peak;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_delay(input int i, input int sinv);
    longint s, m, d;
    s = (sinv < 0) ? -sinv : sinv;
    if (s > 32767) s = 32767;
    m = (sinv >= 0) ? i : NR - 1 - i;
    d = (STEP * m * s) / 32768;
    if (d > DEPTH - 1) d = DEPTH - 1;
    return int'(d);
  endfunction

  function automatic int scale(input int s);
`ifdef RX_AVERAGE_EN
    return s >>> $clog2(NR);
`else
    return s;
`endif
  endfunction

  function automatic logic [NR*SW-1:0] pack(input int v0, input int v1, input int v2, input int v3);
    logic [NR*SW-1:0] r;
    r = {SW'(v3), SW'(v2), SW'(v1), SW'(v0)};
    return r;
  endfunction

  function automatic logic [NR*SW-1:0] rand_x();
    logic [NR*SW-1:0] r;
    for (int i = 0; i < NR; i++) r[i*SW +: SW] = SW'($urandom_range(0, 4095));
    return r;
  endfunction

  // Drive one cycle, advance the model, then compare the registered outputs.
  task automatic step(input bit r, input bit v, input logic [NR*SW-1:0] x,
                      input bit st, input logic signed [SINW-1:0] sn);
    int acc;
    bit exp_valid;
    logic [SUMW-1:0] e;
    @(negedge clk);
    rst_n = r; sv = v; smp = x; stv = st; sin = sn;
    exp_valid = 1'b0;
    if (!r) begin
      k = 0;
      foreach (dly[i]) dly[i] = 0;
      last_sum = 0;
      exp_q.delete();
    end else begin
      if (v) begin
        for (int i = 0; i < NR; i++) hist[i][k] = int'($signed(x[i*SW +: SW]));
        if (k >= DEPTH - 1) begin
          acc = 0;
          for (int i = 0; i < NR; i++) acc += hist[i][k - dly[i]];
          last_sum  = scale(acc);
          exp_valid = 1'b1;
          exp_q.push_back(SUMW'(last_sum));
        end
        k++;
      end
      if (st) for (int i = 0; i < NR; i++) dly[i] = model_delay(i, int'(sn));
    end
    @(posedge clk);
    #1;
    check("sum_valid", longint'(sum_valid), longint'(exp_valid));
    if (exp_valid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("beam_sum_bits", longint'(unsigned'(sum_out)), longint'(e));
    end
    check("sum_value", longint'(sum_out), longint'(last_sum));
    check("filled", longint'(filled), longint'(r && k >= DEPTH));
  endtask

  initial begin
    int valids;
    logic [NR*SW-1:0] x;
    logic signed [SINW-1:0] rs;

    tbl[0] = '{sin: 16'sd0,      d: '{0, 0, 0, 0},    peak: PEAK};
    tbl[1] = '{sin: 16'sd16384,  d: '{0, 7, 15, 22},  peak: PEAK};
    tbl[2] = '{sin: -16'sd32768, d: '{44, 29, 14, 0}, peak: PEAK};
    tbl[3] = '{sin: -16'sd32767, d: '{44, 29, 14, 0}, peak: PEAK};
    tbl[4] = '{sin: 16'sd32767,  d: '{0, 14, 29, 44}, peak: PEAK};
    tbl[5] = '{sin: -16'sd16384, d: '{22, 15, 7, 0},  peak: PEAK};

    rst_n = 1'b0; sv = 1'b0; smp = '0; stv = 1'b0; sin = '0;
    k = 0; last_sum = 0;
    foreach (dly[i]) dly[i] = 0;

    // Reset held three cycles with strobes active.
    for (int j = 0; j < 3; j++) step(1'b0, 1'b1, rand_x(), 1'b0, '0);

    valids = 0;
    for (int j = 0; j < DEPTH - 1; j++) begin
      step(1'b1, 1'b1, rand_x(), 1'b0, '0);
      valids += int'(sum_valid);
    end
    check("fill_no_valid", valids, 0);
    step(1'b1, 1'b1, rand_x(), 1'b0, '0);
    check("first_valid", longint'(sum_valid), 1);
    check("first_filled", longint'(filled), 1);

    // Broadside, constant input.
    step(1'b1, 1'b0, '0, 1'b1, 16'sd0);
    for (int j = 0; j < 8; j++) begin
      step(1'b1, 1'b1, pack(100, 100, 100, 100), 1'b0, '0);
      check("const_sum", longint'(sum_out), CONST);
    end

    // Steering table: impulses placed so the channels align on sample 70.
    for (int r = 0; r < 6; r++) begin
      step(1'b1, 1'b0, '0, 1'b1, tbl[r].sin);
      for (int j = 0; j < 80; j++) begin
        for (int i = 0; i < NR; i++) x[i*SW +: SW] = (j == 70 - tbl[r].d[i]) ? SW'(1000) : '0;
        step(1'b1, 1'b1, x, 1'b0, '0);
        if (j == 70) check("impulse_peak", longint'(sum_out), tbl[r].peak);
        if (j == 69 || j == 71) check("impulse_off", longint'(sum_out), 0);
      end
    end

    // Steering load in the same cycle as a strobe.
    step(1'b1, 1'b0, '0, 1'b1, 16'sd0);
    for (int j = 0; j <= 50; j++) begin
      x = pack(10*j, 10*j + 1, 10*j + 2, 10*j + 3);
      step(1'b1, 1'b1, x, (j == 40), (j == 40) ? 16'sd16384 : 16'sd0);
      if (j == 40) check("sync_steer_old", longint'(sum_out), scale(1606));
      if (j == 41) check("sync_steer_new", longint'(sum_out), scale(1206));
    end

    // Random traffic with occasional steering changes.
    for (int j = 0; j < 300; j++) begin
      case ($urandom_range(0, 3))
        0:       rs = -16'sd32768;
        1:       rs = 16'sd32767;
        default: rs = SINW'($urandom_range(0, 65535));
      endcase
      step(1'b1, ($urandom_range(0, 3) != 0), rand_x(), ($urandom_range(0, 15) == 0), rs);
    end

    // Single-cycle reset during RUN with steering active.
    step(1'b1, 1'b0, '0, 1'b1, 16'sd16384);
    for (int j = 0; j < 10; j++) step(1'b1, 1'b1, rand_x(), 1'b0, '0);
    step(1'b0, 1'b1, rand_x(), 1'b0, '0);
    check("reset_drop_valid", longint'(sum_valid), 0);
    valids = 0;
    for (int j = 0; j < DEPTH - 1; j++) begin
      step(1'b1, 1'b1, rand_x(), 1'b0, '0);
      valids += int'(sum_valid);
    end
    check("refill_no_valid", valids, 0);
    check("refill_not_filled", longint'(filled), 0);
    step(1'b1, 1'b1, pack(100, 100, 100, 100), 1'b0, '0);
    check("refill_valid", longint'(sum_valid), 1);
    check("refill_zero_delay", longint'(sum_out), CONST);
    for (int j = 0; j < 5; j++) step(1'b1, 1'b1, rand_x(), 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
